// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master drives the operands and start; the slave returns results and status.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// The trial subtraction is a full-adder ripple chain computing a + ~b + 1.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    // Working remainder stays below the divisor, so WIDTH bits hold it; the
    // shifted trial operand is widened to WIDTH+1 bits below.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;

    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        addend   = ~{1'b0, dsr_q};
        carry    = '0;
        carry[0] = 1'b1;
        trial    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            trial[i]     = shifted[i] ^ addend[i] ^ carry[i];
            carry[i + 1] = (shifted[i] & addend[i]) | (carry[i] & (shifted[i] ^ addend[i]));
        end
        trial[WIDTH] = shifted[WIDTH] ^ addend[WIDTH] ^ carry[WIDTH];
        // Negative trial (MSB set) restores the shifted remainder.
        rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_nxt = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        dvd_q <= bus.dividend;
                        dsr_q <= bus.divisor;
                        rem_q <= '0;
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q <= rem_nxt;
                    dvd_q <= dvd_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        quotient_q  <= dvd_nxt;
                        remainder_q <= rem_nxt;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
